// File: rtl/shift_frame_pkg.sv
// Shared types for the shift_frame serial/parallel framer.
// SHIFT_FRAME_PARITY_EN adds a trailing even-parity bit to each frame.
package shift_frame_pkg;

  typedef enum logic {S_EMPTY, S_FULL} out_state_t;
  typedef enum logic {ORD_LSB, ORD_MSB} bit_order_t;

  // Serial bits per frame, including the parity bit when enabled
  function automatic int frame_len(input int size);
`ifdef SHIFT_FRAME_PARITY_EN
    return size + 1;
`else
    return size;
`endif
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Bit counter that frames serial words and pulses wrap on the last bit.
// Frame length grows by one bit under SHIFT_FRAME_PARITY_EN.
module frame_bit_counter
  import shift_frame_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int CNT_W = $clog2(frame_len(SIZE) + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(frame_len(SIZE) - 1);

  assign wrap = en && !load && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_frame.sv
// Framed shift register with bit-order select, parallel load and handshaked output.
// SHIFT_FRAME_PARITY_EN: frame carries a trailing even-parity bit, reported on PAR_ERR.
module shift_frame
  import shift_frame_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int CNT_W = $clog2(frame_len(SIZE) + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             IN,
  input  logic             MSB_FIRST,
  input  logic             LOAD,
  input  logic [SIZE-1:0]  LOAD_DATA,
  input  logic             CLR_OVR,
  output logic             SOUT,
  output logic [CNT_W-1:0] BIT_CNT,
  output logic [SIZE-1:0]  OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OVERRUN
`ifdef SHIFT_FRAME_PARITY_EN
  ,
  output logic             PAR_ERR
`endif
);

  out_state_t      state, state_nxt;
  bit_order_t      order, ord_eff;
  logic [SIZE-1:0] sreg, shifted, frame;
  logic            wrap, first, shift;
  logic            out_load, ovr_set;

  frame_bit_counter #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (CLK),
    .rst_n (RESET),
    .en    (EN),
    .load  (LOAD),
    .cnt   (BIT_CNT),
    .wrap  (wrap)
  );

  // First bit of a frame already shifts in the newly sampled order
  assign first   = EN && (BIT_CNT == '0);
  assign ord_eff = (LOAD || first) ? bit_order_t'(MSB_FIRST) : order;
  assign shifted = (ord_eff == ORD_MSB) ? {sreg[SIZE-2:0], IN}
                                        : {IN, sreg[SIZE-1:1]};
  assign SOUT      = (order == ORD_MSB) ? sreg[SIZE-1] : sreg[0];
  assign OUT_VALID = (state == S_FULL);

`ifdef SHIFT_FRAME_PARITY_EN
  logic par_calc;
  assign shift    = EN && !LOAD && (BIT_CNT != CNT_W'(SIZE));
  assign frame    = sreg;
  assign par_calc = ^{sreg, IN};
`else
  assign shift = EN && !LOAD;
  assign frame = shifted;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sreg  <= '0;
      order <= ORD_LSB;
    end else begin
      if (LOAD) sreg <= LOAD_DATA;
      else if (shift) sreg <= shifted;
      if (LOAD || first) order <= ord_eff;
    end
  end

  always_comb begin
    state_nxt = state;
    out_load  = 1'b0;
    ovr_set   = 1'b0;
    unique case (state)
      S_EMPTY: begin
        if (wrap) begin
          out_load  = 1'b1;
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (wrap) begin
          if (OUT_READY) out_load = 1'b1;
          else ovr_set = 1'b1;
        end else if (OUT_READY) begin
          state_nxt = S_EMPTY;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_EMPTY;
      OUT     <= '0;
      OVERRUN <= 1'b0;
    end else begin
      state <= state_nxt;
      if (out_load) OUT <= frame;
      if (ovr_set) OVERRUN <= 1'b1;
      else if (CLR_OVR) OVERRUN <= 1'b0;
    end
  end

`ifdef SHIFT_FRAME_PARITY_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) PAR_ERR <= 1'b0;
    else if (out_load) PAR_ERR <= par_calc;
  end
`endif

endmodule

// File: tb/tb_shift_frame.sv
// Bench for shift_frame: directed frames plus random traffic vs a word-level model.
// Parity checks run when SHIFT_FRAME_PARITY_EN is defined.
module tb_shift_frame;
  import shift_frame_pkg::*;

  localparam int SIZE  = 8;
  localparam int LEN   = frame_len(SIZE);
  localparam int CNT_W = $clog2(LEN + 1);

  logic CLK = 1'b0, RESET = 1'b0;
  logic EN = 1'b0, IN = 1'b0, MSB_FIRST = 1'b0, LOAD = 1'b0;
  logic CLR_OVR = 1'b0, OUT_READY = 1'b0;
  logic [SIZE-1:0]  LOAD_DATA = '0;
  logic [SIZE-1:0]  OUT;
  logic [CNT_W-1:0] BIT_CNT;
  logic SOUT, OUT_VALID, OVERRUN;
`ifdef SHIFT_FRAME_PARITY_EN
  logic PAR_ERR;
`endif

  shift_frame #(.SIZE(SIZE)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .EN        (EN),
    .IN        (IN),
    .MSB_FIRST (MSB_FIRST),
    .LOAD      (LOAD),
    .LOAD_DATA (LOAD_DATA),
    .CLR_OVR   (CLR_OVR),
    .SOUT      (SOUT),
    .BIT_CNT   (BIT_CNT),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OVERRUN   (OVERRUN)
`ifdef SHIFT_FRAME_PARITY_EN
    ,
    .PAR_ERR   (PAR_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  int              m_cnt;
  logic [SIZE-1:0] m_sreg, m_out;
  logic            m_ord, m_valid, m_ovr, m_par;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sreg = '0; m_out = '0;
    m_ord = 0; m_valid = 0; m_ovr = 0; m_par = 0;
  endtask

  task automatic model_step();
    logic first, ord, wrap, ovr_set;
    logic [SIZE-1:0] nxt;
    first   = (m_cnt == 0) && EN;
    ord     = (LOAD || first) ? MSB_FIRST : m_ord;
    wrap    = EN && !LOAD && (m_cnt == LEN - 1);
    ovr_set = 0;
    nxt     = m_sreg;
    if (EN && !LOAD && m_cnt < SIZE)
      nxt = ord ? ((m_sreg << 1) | SIZE'(IN))
                : ((m_sreg >> 1) | (SIZE'(IN) << (SIZE - 1)));
    if (wrap) begin
      if (!m_valid || OUT_READY) begin
        m_out = nxt;
        m_par = (^m_sreg) ^ IN;
        m_valid = 1;
      end else begin
        ovr_set = 1;
      end
    end else if (m_valid && OUT_READY) begin
      m_valid = 0;
    end
    if (LOAD) nxt = LOAD_DATA;
    if (LOAD) m_cnt = 0;
    else if (EN) m_cnt = wrap ? 0 : m_cnt + 1;
    if (LOAD || first) m_ord = ord;
    m_sreg = nxt;
    if (ovr_set) m_ovr = 1;
    else if (CLR_OVR) m_ovr = 0;
  endtask

  task automatic check_all();
    check("bit_cnt", 32'(BIT_CNT), 32'(m_cnt));
    check("out", 32'(OUT), 32'(m_out));
    check("out_valid", 32'(OUT_VALID), 32'(m_valid));
    check("overrun", 32'(OVERRUN), 32'(m_ovr));
    check("sout", 32'(SOUT), 32'(m_ord ? m_sreg[SIZE-1] : m_sreg[0]));
`ifdef SHIFT_FRAME_PARITY_EN
    if (m_valid) check("par_err", 32'(PAR_ERR), 32'(m_par));
`endif
  endtask

  task automatic drive(input logic en, input logic in, input logic msb,
                       input logic ld, input logic [SIZE-1:0] ldd,
                       input logic rdy, input logic clr);
    EN = en; IN = in; MSB_FIRST = msb; LOAD = ld;
    LOAD_DATA = ldd; OUT_READY = rdy; CLR_OVR = clr;
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send(input logic [SIZE-1:0] w, input logic msb,
                      input logic rdy_last, input logic pbit);
    logic b;
    for (int i = 0; i < LEN; i++) begin
      if (i < SIZE) b = msb ? w[SIZE-1-i] : w[i];
      else b = pbit;
      drive(1'b1, b, msb, 1'b0, '0, (i == LEN - 1) ? rdy_last : 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("drained", 32'(OUT_VALID), 32'd0);
  endtask

  initial begin
    logic [SIZE-1:0] a5;
    logic b;
    model_reset();
    #12;
    check("rst_out", 32'(OUT), 32'd0);
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_cnt", 32'(BIT_CNT), 32'd0);
    check("rst_ovr", 32'(OVERRUN), 32'd0);
    RESET = 1'b1;

    send(8'h4D, 1'b0, 1'b0, ^8'h4D);
    check("lsb_out", 32'(OUT), 32'h4D);
    check("lsb_valid", 32'(OUT_VALID), 32'd1);
    check("lsb_cnt", 32'(BIT_CNT), 32'd0);
    drain();

    send(8'hB2, 1'b1, 1'b0, ^8'hB2);
    check("msb_out", 32'(OUT), 32'hB2);
    drain();

    for (int i = 0; i < LEN; i++) begin
      a5 = 8'hB2;
      b  = (i < SIZE) ? a5[SIZE-1-i] : 1'b0;
      drive(1'b1, b, (i < 3), 1'b0, '0, 1'b0, 1'b0);
    end
    check("msb_toggle_out", 32'(OUT), 32'hB2);
    drain();

    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    a5 = 8'hA5;
    for (int k = 0; k < SIZE; k++) begin
      check("load_sout", 32'(SOUT), 32'(a5[k]));
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
`ifdef SHIFT_FRAME_PARITY_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
`endif
    check("load_out", 32'(OUT), 32'h00);
    check("load_valid", 32'(OUT_VALID), 32'd1);
    drain();

    send(8'h3C, 1'b0, 1'b0, ^8'h3C);
    send(8'h81, 1'b0, 1'b0, ^8'h81);
    check("ovr_keep", 32'(OUT), 32'h3C);
    check("ovr_set", 32'(OVERRUN), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("ovr_clr", 32'(OVERRUN), 32'd0);
    send(8'h5A, 1'b0, 1'b1, ^8'h5A);
    check("same_cyc_out", 32'(OUT), 32'h5A);
    check("same_cyc_valid", 32'(OUT_VALID), 32'd1);
    check("same_cyc_ovr", 32'(OVERRUN), 32'd0);
    drain();

    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'(i % 2), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #2 RESET = 1'b0;
    #1;
    check("arst_cnt", 32'(BIT_CNT), 32'd0);
    check("arst_sout", 32'(SOUT), 32'd0);
    check("arst_valid", 32'(OUT_VALID), 32'd0);
    model_reset();
    #1 RESET = 1'b1;
    send(8'hC6, 1'b0, 1'b0, ^8'hC6);
    check("post_rst_out", 32'(OUT), 32'hC6);
    drain();

`ifdef SHIFT_FRAME_PARITY_EN
    send(8'h4D, 1'b0, 1'b0, 1'b0);
    check("par_ok", 32'(PAR_ERR), 32'd0);
    drain();
    send(8'h4D, 1'b0, 1'b0, 1'b1);
    check("par_bad", 32'(PAR_ERR), 32'd1);
    drain();
`endif

    repeat (3000) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom % 2),
            1'($urandom % 2), 1'($urandom_range(0, 19) == 0),
            SIZE'($urandom), 1'($urandom % 2),
            1'($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_frame.md
Name: shift_frame

Overview:
Parametrised successor to the plain LSB-first shift register. It provides a serial shift path with selectable bit order, parallel load, and a bit counter that frames SIZE-bit words. A one-deep output holding register with a valid/ready handshake and a sticky overrun flag sits on the parallel side. It serves as a SIPO deserialiser (receive) and PISO serialiser (transmit) for serial peripherals and bit-serial datapaths.

Parameters:
SIZE, 8, frame width in bits (>=2)
CNT_W, $clog2(SIZE+1), bit-counter width (derived; not overridden)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
EN  in  1  serial bit strobe; one shift per cycle when high
IN  in  1  serial input bit
MSB_FIRST  in  1  bit order: 0 = LSB-first, 1 = MSB-first
LOAD  in  1  parallel load strobe
LOAD_DATA  in  SIZE  parallel load value
CLR_OVR  in  1  synchronous clear of OVERRUN
SOUT  out  1  serial output bit (combinational from shift register)
BIT_CNT  out  CNT_W  bits shifted in current frame
OUT  out  SIZE  holding register (completed frame)
OUT_VALID  out  1  holding register full
OUT_READY  in  1  consumer accepts frame
OVERRUN  out  1  sticky: frame completed while holding register blocked

Behaviour:
- Reset (RESET=0, async): sreg=0, BIT_CNT=0, OUT=0, OUT_VALID=0, OVERRUN=0, latched order=0. Effective immediately; any partial frame is discarded.
- Bit order latch: MSB_FIRST is sampled into an internal order bit when BIT_CNT==0 and EN=1, or on LOAD. Changes mid-frame are ignored until the next frame.
- Shift (EN=1, LOAD=0):
  - LSB-first: sreg <= {IN, sreg[SIZE-1:1]}
  - MSB-first: sreg <= {sreg[SIZE-2:0], IN}
- SOUT = sreg[0] when LSB-first, sreg[SIZE-1] when MSB-first; shows the bit about to leave.
- Counter: BIT_CNT increments per shift. When BIT_CNT==SIZE-1 and EN=1, the frame completes: BIT_CNT <= 0 and the post-shift sreg value is the frame.
- LOAD has priority over EN: sreg <= LOAD_DATA, BIT_CNT <= 0, order latched. No frame completes that cycle.
- Output FSM, two states:
  - EMPTY: OUT_VALID=0. On frame complete: OUT <= frame, go to FULL.
  - FULL: OUT_VALID=1, OUT stable.
    - OUT_READY=1 without a completing frame: go to EMPTY.
    - OUT_READY=1 with a completing frame in the same cycle: OUT <= new frame, stay FULL, no overrun.
    - OUT_READY=0 with a completing frame: OUT unchanged (older frame kept), new frame dropped, OVERRUN <= 1.
- OVERRUN clears only on CLR_OVR=1 or reset. If set and clear coincide, set wins.
- Latency: OUT_VALID rises the cycle after the final EN bit.
- OUT_READY while EMPTY is ignored.

Optional Feature:
SHIFT_FRAME_PARITY_EN
- Defined:
  - Frame is SIZE+1 bits; the last bit is even parity over the data bits and is not shifted into sreg.
  - Extra output PAR_ERR (1 bit) is registered alongside OUT and is valid while OUT_VALID=1. Reset value 0.
  - BIT_CNT counts to SIZE; CNT_W = $clog2(SIZE+2).
- Undefined: no PAR_ERR port; behaviour as above.

Decomposition:
- Package shift_frame_pkg holds:
  - typedef enum logic {S_EMPTY, S_FULL} out_state_t
  - typedef enum logic {ORD_LSB, ORD_MSB} bit_order_t
- Sub-module frame_bit_counter (parametrised SIZE; inputs EN and LOAD; outputs BIT_CNT and a wrap pulse) isolates the framing logic.

Test Plan:
- SIZE=8, LSB-first, IN bits 1,0,1,1,0,0,1,0 (first to last) on 8 EN cycles -> next cycle OUT=0x4D, OUT_VALID=1, BIT_CNT=0.
- Same bit sequence with MSB_FIRST=1 -> OUT=0xB2. Toggling MSB_FIRST at bit 3 -> still 0xB2.
- LOAD 0xA5, LSB-first, 8 EN cycles with IN=0 -> SOUT sequence 1,0,1,0,0,1,0,1; then OUT=0x00, OUT_VALID=1.
- Two frames, OUT_READY=0 -> OUT keeps first frame, OVERRUN=1; CLR_OVR pulse -> OVERRUN=0. Second frame completing on the same cycle as OUT_READY=1 -> OUT=second frame, OUT_VALID stays 1, OVERRUN stays 0.
- Reset asserted after 4 bits -> all outputs 0 asynchronously. A fresh 8 bits afterwards form a correct frame.
- With SHIFT_FRAME_PARITY_EN: data 0x4D plus parity bit 0 -> PAR_ERR=0; parity bit 1 -> PAR_ERR=1.
